// File: rtl/multi_cycle_controller_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, FSM states and
// instruction field positions.
package multi_cycle_controller_pkg;

  localparam logic [2:0] OP_LI   = 3'd0;
  localparam logic [2:0] OP_HALT = 3'd1;
  localparam logic [2:0] OP_BEQ  = 3'd2;
  localparam logic [2:0] OP_BLT  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_AND  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 29;
  localparam int RD_MSB  = 28;
  localparam int RD_LSB  = 26;
  localparam int RS1_MSB = 25;
  localparam int RS1_LSB = 23;
  localparam int RS2_MSB = 22;
  localparam int RS2_LSB = 20;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

endpackage

// File: rtl/multi_cycle_controller_instr_decoder.sv
// Combinational split of the instruction register into register indices,
// zero-extended immediate and instruction class flags.
module multi_cycle_controller_instr_decoder
  import multi_cycle_controller_pkg::*;
#(
  parameter int IMM_W = 20
) (
  input  logic [31:0] ir,
  output logic [2:0]  rd_idx,
  output logic [2:0]  rs1_idx,
  output logic [2:0]  rs2_idx,
  output logic [31:0] imm,
  output logic        is_li,
  output logic        is_halt,
  output logic        is_branch,
  output logic        is_alu
);

  logic [2:0] opcode;

  assign opcode    = ir[OPC_MSB:OPC_LSB];
  assign rd_idx    = ir[RD_MSB:RD_LSB];
  assign rs1_idx   = ir[RS1_MSB:RS1_LSB];
  assign rs2_idx   = ir[RS2_MSB:RS2_LSB];
  assign imm       = {{(32-IMM_W){1'b0}}, ir[IMM_W-1:0]};

  assign is_li     = (opcode == OP_LI);
  assign is_halt   = (opcode == OP_HALT);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BLT);
  assign is_alu    = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR};

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle control FSM: owns PC and IR, sequences fetch/decode/execute/
// writeback and redirects the PC from the ALU branch flag.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_FETCH     | latch instr_rdata at pc into IR
// S_DECODE    | classify IR; LI -> writeback, HALT -> halt, else execute
// S_EXECUTE   | ALU sees opcode; branches resolve pc from change_pc
// S_WRITEBACK | one-cycle reg_we pulse, pc advances by one
// S_HALT      | absorbing until rst
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int IMM_W = 20
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] instr_addr,
  input  logic [31:0]     instr_rdata,
  output logic [2:0]      rs1_idx,
  output logic [2:0]      rs2_idx,
  output logic [2:0]      rd_idx,
  output logic [2:0]      alu_opcode,
  input  logic            change_pc,
  output logic            reg_we,
  output logic            wb_sel,
  output logic [31:0]     imm,
  output logic            halted
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic            reg_we_q;
  logic            is_li;
  logic            is_halt;
  logic            is_branch;
  logic            is_alu;

  multi_cycle_controller_instr_decoder #(
    .IMM_W (IMM_W)
  ) u_decoder (
    .ir        (ir),
    .rd_idx    (rd_idx),
    .rs1_idx   (rs1_idx),
    .rs2_idx   (rs2_idx),
    .imm       (imm),
    .is_li     (is_li),
    .is_halt   (is_halt),
    .is_branch (is_branch),
    .is_alu    (is_alu)
  );

  assign instr_addr = pc;
  // A reset cycle must never write the register file, even mid-writeback.
  assign reg_we     = reg_we_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      reg_we_q   <= 1'b0;
      wb_sel     <= 1'b0;
      halted     <= 1'b0;
      alu_opcode <= OP_LI;
    end else begin
      case (state)
        S_FETCH: begin
          ir         <= instr_rdata;
          alu_opcode <= instr_rdata[OPC_MSB:OPC_LSB];
          state      <= S_DECODE;
        end
        S_DECODE: begin
          if (is_halt) begin
            halted     <= 1'b1;
            alu_opcode <= OP_LI;
            state      <= S_HALT;
          end else if (is_li) begin
            reg_we_q <= 1'b1;
            wb_sel   <= 1'b1;
            state    <= S_WRITEBACK;
          end else if (is_branch || is_alu) begin
            state <= S_EXECUTE;
          end else begin
            state <= S_FETCH;
          end
        end
        S_EXECUTE: begin
          if (is_alu) begin
            reg_we_q <= 1'b1;
            wb_sel   <= 1'b0;
            state    <= S_WRITEBACK;
          end else begin
            // Offset is the low PC_W imm bits; modulo add gives sign extension.
            pc         <= change_pc ? pc + ir[PC_W-1:0] : pc + PC_ONE;
            alu_opcode <= OP_LI;
            state      <= S_FETCH;
          end
        end
        S_WRITEBACK: begin
          reg_we_q   <= 1'b0;
          wb_sel     <= 1'b0;
          pc         <= pc + PC_ONE;
          alu_opcode <= OP_LI;
          state      <= S_FETCH;
        end
        S_HALT: begin
          halted   <= 1'b1;
          reg_we_q <= 1'b0;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench: instruction-level model of the controller checked every
// cycle, directed scenarios with literal expectations, then random programs.
module tb_multi_cycle_controller;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            change_pc = 1'b0;
  logic [PC_W-1:0] instr_addr;
  logic [31:0]     instr_rdata;
  logic [2:0]      rs1_idx, rs2_idx, rd_idx, alu_opcode;
  logic            reg_we, wb_sel, halted;
  logic [31:0]     imm;

  logic [31:0] mem [256];
  assign instr_rdata = mem[instr_addr];

  multi_cycle_controller #(.PC_W(PC_W), .IMM_W(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_addr  (instr_addr),
    .instr_rdata (instr_rdata),
    .rs1_idx     (rs1_idx),
    .rs2_idx     (rs2_idx),
    .rd_idx      (rd_idx),
    .alu_opcode  (alu_opcode),
    .change_pc   (change_pc),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .imm         (imm),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: current instruction address, cycle index within the instruction.
  logic [7:0]  m_pc = 8'd0;
  int          m_k = 0;
  logic        m_halted = 1'b0;
  logic [31:0] m_ir = 32'd0;

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [19:0] im);
    return {op, rd, rs1, rs2, im};
  endfunction

  // Cycles per instruction class, from the latency table.
  function automatic int op_cycles(input logic [2:0] op);
    if (op == 3'd1) return 2;
    if (op == 3'd0 || op == 3'd2 || op == 3'd3) return 3;
    return 4;
  endfunction

  function automatic logic op_writes(input logic [2:0] op);
    return (op == 3'd0) || (op >= 3'd4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    logic [2:0] op;
    logic [2:0] exp_alu;
    logic       exp_we;
    op = m_ir[31:29];
    chk("instr_addr", 32'(instr_addr), 32'(m_pc));
    chk("halted", 32'(halted), 32'(m_halted));
    if (m_halted) begin
      exp_alu = 3'd0;
      exp_we  = 1'b0;
    end else begin
      exp_alu = (m_k == 0) ? 3'd0 : op;
      exp_we  = (m_k == op_cycles(op) - 1) && op_writes(op) && !rst;
    end
    chk("alu_opcode", 32'(alu_opcode), 32'(exp_alu));
    chk("reg_we", 32'(reg_we), 32'(exp_we));
    if (exp_we) chk("wb_sel", 32'(wb_sel), 32'(op == 3'd0));
    if (!m_halted && m_k >= 1) begin
      chk("rd_idx", 32'(rd_idx), 32'(m_ir[28:26]));
      chk("rs1_idx", 32'(rs1_idx), 32'(m_ir[25:23]));
      chk("rs2_idx", 32'(rs2_idx), 32'(m_ir[22:20]));
      chk("imm", imm, {12'd0, m_ir[19:0]});
    end
  endtask

  task automatic advance();
    logic [2:0] op;
    if (rst) begin
      m_pc = 8'd0;
      m_k = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_k == 0) begin
        m_ir = mem[m_pc];
        m_k = 1;
      end else begin
        op = m_ir[31:29];
        if (m_k == op_cycles(op) - 1) begin
          if (op == 3'd1) m_halted = 1'b1;
          else if (op == 3'd2 || op == 3'd3) m_pc = change_pc ? m_pc + m_ir[7:0] : m_pc + 8'd1;
          else m_pc = m_pc + 8'd1;
          m_k = 0;
        end else begin
          m_k++;
        end
      end
    end
  endtask

  // One clock: model follows the edge, new inputs applied, outputs checked at negedge.
  task automatic tick(input logic r, input logic cp);
    @(posedge clk);
    advance();
    #1;
    rst = r;
    change_pc = cp;
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = mk(3'd1, 3'd0, 3'd0, 3'd0, 20'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [2:0] op;
    op = 3'($urandom_range(0, 7));
    if (op == 3'd1 && $urandom_range(0, 9) != 0) op = 3'd4;
    return {op, 29'($urandom)};
  endfunction

  initial begin
    clear_mem();

    // Reset state
    do_reset();
    chk("rst_instr_addr", 32'(instr_addr), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_reg_we", 32'(reg_we), 32'h0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'h0);

    // LI r3, 0x0ABCD: writeback in cycle 3
    mem[0] = mk(3'd0, 3'd3, 3'd0, 3'd0, 20'h0ABCD);
    do_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("li_reg_we", 32'(reg_we), 32'h1);
    chk("li_wb_sel", 32'(wb_sel), 32'h1);
    chk("li_rd_idx", 32'(rd_idx), 32'h3);
    chk("li_imm", imm, 32'h0000ABCD);
    tick(1'b0, 1'b0);
    chk("li_pc", 32'(instr_addr), 32'h1);

    // ADD r1, r2, r4: execute cycle 3, writeback cycle 4
    mem[0] = mk(3'd4, 3'd1, 3'd2, 3'd4, 20'h0);
    do_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("add_alu_opcode", 32'(alu_opcode), 32'h4);
    chk("add_we_exec", 32'(reg_we), 32'h0);
    tick(1'b0, 1'b0);
    chk("add_reg_we", 32'(reg_we), 32'h1);
    chk("add_wb_sel", 32'(wb_sel), 32'h0);
    tick(1'b0, 1'b0);
    chk("add_pc", 32'(instr_addr), 32'h1);
    chk("add_we_once", 32'(reg_we), 32'h0);

    // Reset asserted during EXECUTE of ADD
    do_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("rstx_pc", 32'(instr_addr), 32'h0);
    chk("rstx_alu", 32'(alu_opcode), 32'h0);
    chk("rstx_we", 32'(reg_we), 32'h0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("rstx_we_exec", 32'(reg_we), 32'h0);

    // Reset asserted during WRITEBACK suppresses the write
    do_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("rstwb_we", 32'(reg_we), 32'h0);
    tick(1'b0, 1'b0);
    chk("rstwb_pc", 32'(instr_addr), 32'h0);

    // BEQ +10 from pc 0 (taken), then BEQ -2 at pc 10 taken / not taken
    for (int t = 0; t < 2; t++) begin
      mem[0]  = mk(3'd2, 3'd0, 3'd1, 3'd2, 20'h0000A);
      mem[10] = mk(3'd2, 3'd0, 3'd1, 3'd2, 20'h000FE);
      do_reset();
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      chk("beq_to10", 32'(instr_addr), 32'd10);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'(t == 0));
      tick(1'b0, 1'b0);
      chk(t == 0 ? "beq_taken" : "beq_not_taken", 32'(instr_addr), t == 0 ? 32'd8 : 32'd11);
    end

    // Wrap at pc 0xFF: BLT not taken, BEQ +2 taken, LI
    for (int t = 0; t < 3; t++) begin
      mem[0]   = mk(3'd2, 3'd0, 3'd0, 3'd0, 20'h000FF);
      mem[255] = (t == 0) ? mk(3'd3, 3'd0, 3'd0, 3'd0, 20'h00005) :
                 (t == 1) ? mk(3'd2, 3'd0, 3'd0, 3'd0, 20'h00002) :
                            mk(3'd0, 3'd5, 3'd0, 3'd0, 20'h12345);
      do_reset();
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      chk("wrap_to_ff", 32'(instr_addr), 32'hFF);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'(t == 1));
      tick(1'b0, 1'b0);
      chk("wrap_pc", 32'(instr_addr), t == 1 ? 32'h01 : 32'h00);
    end

    // HALT: halted after 2 cycles, absorbing, cleared by rst
    clear_mem();
    do_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("halt_not_yet", 32'(halted), 32'h0);
    tick(1'b0, 1'b0);
    chk("halt_set", 32'(halted), 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)));
      chk("halt_hold", 32'(halted), 32'h1);
      chk("halt_pc", 32'(instr_addr), 32'h0);
      chk("halt_we", 32'(reg_we), 32'h0);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("halt_cleared", 32'(halted), 32'h0);

    // Random programs with occasional resets
    for (int i = 0; i < 256; i++) mem[i] = rand_instr();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tick(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
